// File: rtl/sata_bist_target.sv
// BIST device-side responder: accepts {len,addr} commands, sinks write bursts
// into a dword RAM and streams stored dwords back for read commands.
module sata_bist_target #(
  parameter int MEM_AW  = 10,
  parameter int ACK_DLY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [70:0] cmd_dat,
  input  logic        cmd_wr,
  input  logic        cmd_req,
  output logic        cmd_ack,
  input  logic [31:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        err_inject,
  output logic        busy,
  output logic [31:0] wr_burst_cnt,
  output logic [31:0] rd_burst_cnt,
  output logic [31:0] len_err_cnt
);

  typedef enum logic [2:0] {IDLE, WAIT, ACK, WR_DATA, RD_DATA} state_t;

  state_t            state_q;
  logic [7:0]        dly_q;
  logic [MEM_AW-1:0] base_q;
  logic [20:0]       last_q;
  logic [20:0]       bcnt_q;
  logic              err_q;
  logic              fetched_q;
  logic              cmd_ack_q;
  logic              s_tready_q;
  logic [31:0]       m_tdata_q;
  logic [7:0]        m_tuser_q;
  logic              m_tvalid_q;
  logic              busy_q;
  logic [31:0]       wr_cnt_q;
  logic [31:0]       rd_cnt_q;
  logic [31:0]       le_cnt_q;

  logic [31:0]       mem [2**MEM_AW];

  logic              beat_last;
  logic              wr_en;
  logic [MEM_AW-1:0] idx;
  logic              unused_bits;

  // bcnt_q indexes the write beat, or the next beat to fetch on reads
  assign beat_last = (bcnt_q == last_q);
  assign idx       = base_q + MEM_AW'(bcnt_q);
  assign wr_en     = rst_n && (state_q == WR_DATA) && s_axis_tvalid && !s_axis_tuser[7];

  assign unused_bits = ^{cmd_dat[47:MEM_AW+2], cmd_dat[49:48], cmd_dat[1:0], s_axis_tuser[6:1]};

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      base_q     <= '0;
      last_q     <= '0;
      bcnt_q     <= '0;
      err_q      <= 1'b0;
      fetched_q  <= 1'b0;
      cmd_ack_q  <= 1'b0;
      s_tready_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      le_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_req) begin
            busy_q <= 1'b1;
            if (ACK_DLY > 0) begin
              state_q <= WAIT;
              dly_q   <= 8'(ACK_DLY - 1);
            end else begin
              state_q   <= ACK;
              cmd_ack_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (dly_q == 8'd0) begin
            state_q   <= ACK;
            cmd_ack_q <= 1'b1;
          end else begin
            dly_q <= dly_q - 8'd1;
          end
        end
        ACK: begin
          cmd_ack_q <= 1'b0;
          base_q    <= cmd_dat[MEM_AW+1:2];
          // len[22:2]==0 wraps to 2^21-1, i.e. a 2^21-beat burst
          last_q    <= cmd_dat[70:50] - 21'd1;
          bcnt_q    <= '0;
          err_q     <= cmd_wr & err_inject;
          fetched_q <= 1'b0;
          if (cmd_wr) begin
            state_q <= RD_DATA;
          end else begin
            state_q    <= WR_DATA;
            s_tready_q <= 1'b1;
          end
        end
        WR_DATA: begin
          if (s_axis_tvalid) begin
            bcnt_q <= bcnt_q + 21'd1;
            if (s_axis_tuser[0] || beat_last) begin
              state_q    <= IDLE;
              s_tready_q <= 1'b0;
              busy_q     <= 1'b0;
              wr_cnt_q   <= wr_cnt_q + 32'd1;
              if (s_axis_tuser[0] != beat_last) le_cnt_q <= le_cnt_q + 32'd1;
            end
          end
        end
        RD_DATA: begin
          if (m_tvalid_q && m_axis_tready && m_tuser_q[0]) begin
            state_q    <= IDLE;
            m_tvalid_q <= 1'b0;
            busy_q     <= 1'b0;
            rd_cnt_q   <= rd_cnt_q + 32'd1;
          end else if (!fetched_q && (!m_tvalid_q || m_axis_tready)) begin
            // output register doubles as the RAM read register
            m_tdata_q  <= mem[idx];
            m_tuser_q  <= {1'b0, err_q && beat_last, 4'b1111, bcnt_q == 21'd0, beat_last};
            m_tvalid_q <= 1'b1;
            bcnt_q     <= bcnt_q + 21'd1;
            if (beat_last) fetched_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ack       = cmd_ack_q;
  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign busy          = busy_q;
  assign wr_burst_cnt  = wr_cnt_q;
  assign rd_burst_cnt  = rd_cnt_q;
  assign len_err_cnt   = le_cnt_q;

endmodule

// File: tb/tb_sata_bist_target.sv
// Directed bench for sata_bist_target: default instance plus a small-RAM,
// delayed-ack instance selected through sel.
module tb_sata_bist_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [70:0] cmd_dat;
  logic        cmd_wr, cmd_req, err_inject;
  logic [31:0] s_tdata;
  logic [7:0]  s_tuser;
  logic        s_tvalid, m_tready;
  logic        sel;

  logic        ack_v[2], str_v[2], mtv_v[2], busy_v[2];
  logic [31:0] mtd_v[2], wrc_v[2], rdc_v[2], lec_v[2];
  logic [7:0]  mtu_v[2];

  logic        ack, s_tready, mtv, busy;
  logic [31:0] mtd, wrc, rdc, lec;
  logic [7:0]  mtu;

  logic [31:0] exp_d[64];
  logic [7:0]  exp_u[64];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  sata_bist_target dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_dat(cmd_dat), .cmd_wr(cmd_wr),
    .cmd_req(cmd_req && !sel), .cmd_ack(ack_v[0]),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid && !sel),
    .s_axis_tready(str_v[0]), .m_axis_tdata(mtd_v[0]), .m_axis_tuser(mtu_v[0]),
    .m_axis_tvalid(mtv_v[0]), .m_axis_tready(m_tready), .err_inject(err_inject),
    .busy(busy_v[0]), .wr_burst_cnt(wrc_v[0]), .rd_burst_cnt(rdc_v[0]), .len_err_cnt(lec_v[0])
  );

  sata_bist_target #(.MEM_AW(4), .ACK_DLY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_dat(cmd_dat), .cmd_wr(cmd_wr),
    .cmd_req(cmd_req && sel), .cmd_ack(ack_v[1]),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid && sel),
    .s_axis_tready(str_v[1]), .m_axis_tdata(mtd_v[1]), .m_axis_tuser(mtu_v[1]),
    .m_axis_tvalid(mtv_v[1]), .m_axis_tready(m_tready), .err_inject(err_inject),
    .busy(busy_v[1]), .wr_burst_cnt(wrc_v[1]), .rd_burst_cnt(rdc_v[1]), .len_err_cnt(lec_v[1])
  );

  assign ack      = ack_v[sel];
  assign s_tready = str_v[sel];
  assign mtv      = mtv_v[sel];
  assign busy     = busy_v[sel];
  assign mtd      = mtd_v[sel];
  assign mtu      = mtu_v[sel];
  assign wrc      = wrc_v[sel];
  assign rdc      = rdc_v[sel];
  assign lec      = lec_v[sel];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_counts(input int w, input int r, input int e);
    check("wr_burst_cnt", wrc, w);
    check("rd_burst_cnt", rdc, r);
    check("len_err_cnt", lec, e);
  endtask

  task automatic check_idle_outputs;
    check("ack_zero", ack, 0);
    check("tready_zero", s_tready, 0);
    check("tvalid_zero", mtv, 0);
    check("tdata_zero", mtd, 0);
    check("tuser_zero", mtu, 0);
    check("busy_zero", busy, 0);
    check_counts(0, 0, 0);
  endtask

  task automatic do_cmd(input logic rd, input logic [22:0] len, input logic [47:0] addr,
                        input logic err, input int exp_cyc);
    int cyc;
    cmd_dat    = {len, addr};
    cmd_wr     = rd;
    err_inject = err;
    cmd_req    = 1'b1;
    cyc        = 0;
    do begin
      tick();
      cyc++;
    end while (!ack && cyc < 300);
    check("ack_cycles", cyc, exp_cyc);
    tick();
    cmd_req    = 1'b0;
    err_inject = 1'b0;
    check("ack_pulse", ack, 0);
  endtask

  task automatic wr_burst(input int n, input logic [31:0] d0, input int eop_at);
    int t;
    for (int i = 0; i < n; i++) begin
      s_tdata  = d0 + i;
      s_tuser  = {2'b00, 4'hF, i == 0, i == eop_at};
      s_tvalid = 1'b1;
      t = 0;
      while (!s_tready && t < 50) begin
        tick();
        t++;
      end
      if (!s_tready) check("wr_ready_timeout", s_tready, 1);
      tick();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic set_exp(input int n, input logic [31:0] d0, input logic err);
    for (int i = 0; i < n; i++) begin
      exp_d[i] = d0 + i;
      exp_u[i] = {1'b0, err && (i == n - 1), 4'hF, i == 0, i == n - 1};
    end
  endtask

  task automatic rd_burst(input int n, input logic bp);
    int k, t;
    logic pv, ptr;
    logic [31:0] pd;
    logic [7:0]  pu;
    k = 0; t = 0; pv = 1'b0; ptr = 1'b0; pd = '0; pu = '0;
    while (k < n && t < 400) begin
      m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !ptr) begin
        check("rd_hold_data", mtd, pd);
        check("rd_hold_user", mtu, pu);
      end
      if (k > 0) check("rd_no_gap", mtv, 1);
      if (mtv && m_tready) begin
        check("rd_data", mtd, exp_d[k]);
        check("rd_user", mtu, exp_u[k]);
        k++;
      end
      pv = mtv; ptr = m_tready; pd = mtd; pu = mtu;
      tick();
      t++;
    end
    check("rd_beats", k, n);
    check("rd_vld_after_last", mtv, 0);
    check("rd_busy_after_last", busy, 0);
    m_tready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; sel = 1'b0; cmd_dat = '0; cmd_wr = 1'b0; cmd_req = 1'b0;
    err_inject = 1'b0; s_tdata = '0; s_tuser = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    tick(); tick();
    check_idle_outputs();
    rst_n = 1'b1;
    tick();

    // write then read back
    do_cmd(1'b0, 23'd16, 48'h100, 1'b0, 1);
    check("wr_busy", busy, 1);
    wr_burst(4, 32'hA5A5_0000, 3);
    check("wr_tready_off", s_tready, 0);
    do_cmd(1'b1, 23'd16, 48'h100, 1'b0, 1);
    set_exp(4, 32'hA5A5_0000, 1'b0);
    rd_burst(4, 1'b0);
    check_counts(1, 1, 0);

    // read under random backpressure
    do_cmd(1'b0, 23'd64, 48'h200, 1'b0, 1);
    wr_burst(16, 32'h1000_0000, 15);
    do_cmd(1'b1, 23'd64, 48'h200, 1'b0, 1);
    set_exp(16, 32'h1000_0000, 1'b0);
    rd_burst(16, 1'b1);
    check_counts(2, 2, 0);

    // early eop ends a write burst and counts a length error
    do_cmd(1'b0, 23'd32, 48'h400, 1'b0, 1);
    wr_burst(4, 32'h2000_0000, 3);
    check("early_eop_tready", s_tready, 0);
    check("early_eop_busy", busy, 0);
    check_counts(3, 2, 1);
    do_cmd(1'b1, 23'd16, 48'h400, 1'b0, 1);
    set_exp(4, 32'h2000_0000, 1'b0);
    rd_burst(4, 1'b0);

    // last beat without eop is also a length error
    do_cmd(1'b0, 23'd8, 48'h600, 1'b0, 1);
    wr_burst(2, 32'h3000_0000, 99);
    check("no_eop_busy", busy, 0);
    check_counts(4, 3, 2);

    // small RAM wraps, delayed ack, injected error on eop
    sel = 1'b1;
    tick();
    do_cmd(1'b0, 23'd16, 48'h38, 1'b0, 4);
    wr_burst(4, 32'hC0DE_0000, 3);
    do_cmd(1'b1, 23'd8, 48'h0, 1'b1, 4);
    set_exp(2, 32'hC0DE_0002, 1'b1);
    rd_burst(2, 1'b0);
    check_counts(1, 1, 0);

    // reset in the middle of a read burst
    sel = 1'b0;
    tick();
    do_cmd(1'b1, 23'd32, 48'h200, 1'b0, 1);
    m_tready = 1'b1;
    t = 0;
    while (!mtv && t < 10) begin
      tick();
      t++;
    end
    check("rst_beat0", mtd, 32'h1000_0000);
    tick();
    check("rst_beat1", mtd, 32'h1000_0001);
    tick();
    check("rst_beat2_vld", mtv, 1);
    rst_n = 1'b0;
    tick();
    check_idle_outputs();
    rst_n = 1'b1;
    m_tready = 1'b0;
    tick();
    do_cmd(1'b1, 23'd8, 48'h100, 1'b0, 1);
    set_exp(2, 32'hA5A5_0000, 1'b0);
    exp_u[0] = 8'h3E;
    exp_u[1] = 8'h3D;
    rd_burst(2, 1'b0);
    check_counts(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
